// File: rtl/complemento2_serial_pkg.sv
// Shared types and encodings for the serial two's-complement unit.
package complemento2_serial_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [MODE_W-1:0] MODE_PASS = 2'b00;
    localparam logic [MODE_W-1:0] MODE_NEG  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_ABS  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_SM   = 2'b11;

    // Whether the operand gets inverted-and-incremented, given mode and operand sign.
    function automatic logic neg_flag(input logic [MODE_W-1:0] mode, input logic sign);
        logic f;
        f = 1'b0;
        case (mode)
            MODE_PASS: f = 1'b0;
            MODE_NEG:  f = 1'b1;
            MODE_ABS:  f = sign;
            MODE_SM:   f = sign;
            default:   f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/complemento2_serial_slice.sv
// K-bit conditional invert-and-add slice with carry in/out.
module comp2_slice #(
    parameter int unsigned K = 2
) (
    input  logic [K-1:0] a,
    input  logic         neg,
    input  logic         c_in,
    output logic [K-1:0] s,
    output logic         c_out
);

    logic [K:0] sum;

    // Invert the slice when negating, then add the chained carry.
    always_comb begin
        sum   = {1'b0, a ^ {K{neg}}} + (K+1)'(c_in);
        s     = sum[K-1:0];
        c_out = sum[K];
    end

endmodule

// File: rtl/complemento2_serial.sv
// Serial pass/negate/abs/sign-magnitude converter, K bits per cycle, LSB first.
module complemento2_serial
    import complemento2_serial_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned K = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [N-1:0]      X,
    output logic [N-1:0]      Y,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int unsigned SLICES = N / K;
    localparam int unsigned CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLICES - 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  op_q;
    logic          neg_q;
    logic          carry_q;
    logic          ovf_pend_q;

    logic [N-1:0]  op_src_c;
    logic [K-1:0]  slice_a_c;
    logic [K-1:0]  slice_s_c;
    logic          slice_co_c;

    // Operand source selection; sign-magnitude drops the sign bit.
    always_comb begin
        op_src_c  = (mode == MODE_SM) ? {1'b0, X[N-2:0]} : X;
        slice_a_c = K'(op_q >> (32'(cnt) * K));
    end

    comp2_slice #(.K(K)) u_slice (
        .a     (slice_a_c),
        .neg   (neg_q),
        .c_in  (carry_q),
        .s     (slice_s_c),
        .c_out (slice_co_c)
    );

    // Control FSM, slice write-back and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            carry_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            Y          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= op_src_c;
                        neg_q      <= neg_flag(mode, X[N-1]);
                        carry_q    <= neg_flag(mode, X[N-1]);
                        ovf_pend_q <= ((mode == MODE_NEG) || (mode == MODE_ABS)) && (X == MIN_NEG);
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    Y[32'(cnt) * K +: K] <= slice_s_c;
                    carry_q              <= slice_co_c;
                    if (cnt == LAST) begin
                        ovf   <= ovf_pend_q;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_complemento2_serial.sv
// Directed bench for complemento2_serial: N=8/K=2 vectors plus N=16 parameter sweep.
module tb_complemento2_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy, done, ovf;

    logic        start16;
    logic [1:0]  mode16;
    logic [15:0] x16;
    logic [15:0] y16_1, y16_4, y16_16;
    logic        busy16_1, busy16_4, busy16_16;
    logic        done16_1, done16_4, done16_16;
    logic        ovf16_1, ovf16_4, ovf16_16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    complemento2_serial #(.N(8), .K(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .X(x),
        .Y(y), .busy(busy), .done(done), .ovf(ovf)
    );

    complemento2_serial #(.N(16), .K(1)) dut16_1 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .X(x16),
        .Y(y16_1), .busy(busy16_1), .done(done16_1), .ovf(ovf16_1)
    );

    complemento2_serial #(.N(16), .K(4)) dut16_4 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .X(x16),
        .Y(y16_4), .busy(busy16_4), .done(done16_4), .ovf(ovf16_4)
    );

    complemento2_serial #(.N(16), .K(16)) dut16_16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .X(x16),
        .Y(y16_16), .busy(busy16_16), .done(done16_16), .ovf(ovf16_16)
    );

    typedef struct {
        logic [1:0] mode;
        logic [7:0] x;
        logic [7:0] y;
        logic       ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one N=8 operation and watch it to completion (bounded).
    task automatic run8(input logic [1:0] m, input logic [7:0] xv,
                        output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b1; mode = m; x = xv;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy) busy_cycles++;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    // Independent reference for the N=16 sweep.
    function automatic logic [16:0] ref16(input logic [1:0] m, input logic [15:0] xv);
        logic [15:0] r;
        logic        o;
        case (m)
            2'b00: r = xv;
            2'b01: r = -xv;
            2'b10: r = xv[15] ? -xv : xv;
            default: r = xv[15] ? -{1'b0, xv[14:0]} : {1'b0, xv[14:0]};
        endcase
        o = ((m == 2'b01) || (m == 2'b10)) && (xv == 16'h8000);
        return {o, r};
    endfunction

    task automatic run16(input logic [1:0] m, input logic [15:0] xv, input int idx);
        int l1, l4, l16;
        logic [16:0] e;
        l1 = 0; l4 = 0; l16 = 0;
        e = ref16(m, xv);
        @(negedge clk);
        start16 = 1'b1; mode16 = m; x16 = xv;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk); #1;
            if (done16_1  && l1  == 0) l1  = i;
            if (done16_4  && l4  == 0) l4  = i;
            if (done16_16 && l16 == 0) l16 = i;
        end
        check($sformatf("k1_y[%0d]", idx),   32'(y16_1),  32'(e[15:0]));
        check($sformatf("k1_ovf[%0d]", idx), 32'(ovf16_1), 32'(e[16]));
        check($sformatf("k1_lat[%0d]", idx), 32'(l1), 32'd17);
        check($sformatf("k4_y[%0d]", idx),   32'(y16_4),  32'(e[15:0]));
        check($sformatf("k4_ovf[%0d]", idx), 32'(ovf16_4), 32'(e[16]));
        check($sformatf("k4_lat[%0d]", idx), 32'(l4), 32'd5);
        check($sformatf("k16_y[%0d]", idx),   32'(y16_16),  32'(e[15:0]));
        check($sformatf("k16_ovf[%0d]", idx), 32'(ovf16_16), 32'(e[16]));
        check($sformatf("k16_lat[%0d]", idx), 32'(l16), 32'd2);
    endtask

    initial begin
        int lat, bc, ndone;

        vecs[0]  = '{2'b01, 8'h05, 8'hFB, 1'b0};
        vecs[1]  = '{2'b10, 8'hF6, 8'h0A, 1'b0};
        vecs[2]  = '{2'b10, 8'h0A, 8'h0A, 1'b0};
        vecs[3]  = '{2'b01, 8'h80, 8'h80, 1'b1};
        vecs[4]  = '{2'b10, 8'h80, 8'h80, 1'b1};
        vecs[5]  = '{2'b11, 8'h80, 8'h00, 1'b0};
        vecs[6]  = '{2'b11, 8'h83, 8'hFD, 1'b0};
        vecs[7]  = '{2'b00, 8'h3C, 8'h3C, 1'b0};
        vecs[8]  = '{2'b01, 8'h00, 8'h00, 1'b0};
        vecs[9]  = '{2'b01, 8'h7F, 8'h81, 1'b0};
        vecs[10] = '{2'b00, 8'h80, 8'h80, 1'b0};
        vecs[11] = '{2'b11, 8'h7F, 8'h7F, 1'b0};
        vecs[12] = '{2'b11, 8'hFF, 8'h81, 1'b0};
        vecs[13] = '{2'b10, 8'hFF, 8'h01, 1'b0};

        rst = 1'b1; start = 1'b0; mode = 2'b00; x = 8'h00;
        start16 = 1'b0; mode16 = 2'b00; x16 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y",    32'(y),    32'h0);
        check("reset_ovf",  32'(ovf),  32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            run8(vecs[i].mode, vecs[i].x, lat, bc);
            check($sformatf("y[%0d]", i),    32'(y),   32'(vecs[i].y));
            check($sformatf("ovf[%0d]", i),  32'(ovf), 32'(vecs[i].ovf));
            check($sformatf("lat[%0d]", i),  32'(lat), 32'd5);
            check($sformatf("busy[%0d]", i), 32'(bc),  32'd4);
            @(posedge clk); #1;
            check($sformatf("done_width[%0d]", i), 32'(done), 32'h0);
            check($sformatf("y_hold[%0d]", i),     32'(y),    32'(vecs[i].y));
        end

        // start pulsed during RUN is ignored
        @(negedge clk);
        start = 1'b1; mode = 2'b01; x = 8'h05;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin start = 1'b1; mode = 2'b00; x = 8'h0A; end
            if (i == 3) start = 1'b0;
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("run_pulse_dones", 32'(ndone), 32'd1);
        check("run_pulse_y",     32'(y),     32'hFB);

        // start held high: one done per acceptance (edges 0 and 6)
        @(negedge clk);
        start = 1'b1; mode = 2'b01; x = 8'h05;
        @(posedge clk); #1;
        ndone = 0;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        start = 1'b0;
        check("held_dones", 32'(ndone), 32'd2);
        check("held_y",     32'(y),     32'hFB);
        repeat (3) @(posedge clk);

        // Reset in the second RUN cycle aborts with no done
        @(negedge clk);
        start = 1'b1; mode = 2'b01; x = 8'h05;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_y",    32'(y),    32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_ovf",  32'(ovf),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        run8(2'b00, 8'h3C, lat, bc);
        check("after_abort_y",   32'(y),   32'h3C);
        check("after_abort_lat", 32'(lat), 32'd5);

        // N=16 sweep over K=1,4,16
        run16(2'b01, 16'h8000, 0);
        run16(2'b10, 16'h8000, 1);
        run16(2'b11, 16'h8000, 2);
        for (int i = 3; i < 11; i++) begin
            run16(2'($urandom_range(0, 3)), 16'($urandom), i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complemento2_serial.md
COMPLEMENTO2_SERIAL -- requirements
Module: complemento2_serial

Interface
REQ-001 Parameter N, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter K, default 2, bits processed per cycle; SHALL divide N exactly.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 mode  input  2  operation: 00 pass, 01 negate, 10 absolute value, 11 sign-magnitude to two's complement.
REQ-007 X  input  N  operand; captured with mode on an accepted start.
REQ-008 Y  output  N  result register.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse marking Y valid.
REQ-011 ovf  output  1  result not representable; valid with done.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 IDLE with start=1: capture X and mode, load slice counter to 0, go to RUN; otherwise stay in IDLE.
REQ-014 start in RUN or DONE SHALL be ignored, with no queueing.
REQ-015 Negate flag NEG, fixed at capture: mode 01 -> 1; mode 10 or 11 -> X[N-1]; mode 00 -> 0.
REQ-016 Operand source: mode 11 uses {1'b0, X[N-2:0]}; all other modes use X.
REQ-017 RUN SHALL process one K-bit slice per cycle, LSB first, over exactly N/K cycles.
REQ-018 Slice computation: if NEG, out = ~slice + carry; else out = slice + carry.
  - Carry SHALL be initialised to NEG and chained between slices in a registered 1-bit carry.
  - out is written into the matching K bits of the result.
REQ-019 After the last slice, the FSM SHALL go to DONE, where done=1 for exactly one cycle; it then returns to IDLE.
REQ-020 Latency SHALL be N/K+1 cycles from the start-sampling edge to done high; for N=8, K=2 this is 5 cycles.
REQ-021 Y SHALL change only at slice writes and SHALL hold its value from DONE until the next accepted start.
REQ-022 ovf=1 only when mode is 01 or 10 and X = 1 followed by N-1 zeros (most negative value).
  - In that case Y SHALL equal X.
REQ-023 Mode 11 with X = 1 followed by zeros (negative zero) SHALL give Y=0 and ovf=0.
REQ-024 ovf SHALL be registered with the final slice and held with Y.
REQ-025 Arithmetic is modulo 2^N; no saturation.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, Y=0, ovf=0, done=0, busy=0, carry=0, counter=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL be served normally.

Structure
REQ-028 A shared package SHALL hold:
  - the state enumeration IDLE/RUN/DONE;
  - the mode encodings MODE_PASS, MODE_NEG, MODE_ABS, MODE_SM.
REQ-029 The K-bit invert-and-add slice SHALL be one sub-module, comp2_slice.
  - Ports: a[K], neg, c_in, s[K], c_out.
  - Purely combinational.
REQ-030 The counter width SHALL be derived from N/K via $clog2, with a minimum of 1.

Verification
REQ-031 N=8, K=2, mode 01, X=8'h05, start one cycle -> done 5 cycles later, Y=8'hFB, ovf=0, busy high for 4 cycles.
REQ-032 mode 10, X=8'hF6 -> Y=8'h0A; mode 10, X=8'h0A -> Y=8'h0A; both with ovf=0.
REQ-033 mode 01 and mode 10, X=8'h80 -> Y=8'h80, ovf=1.
  - mode 11, X=8'h80 -> Y=8'h00, ovf=0.
  - mode 11, X=8'h83 -> Y=8'hFD, ovf=0.
REQ-034 start held high continuously, or pulsed during RUN -> exactly one done per IDLE acceptance; Y is unchanged by the ignored starts.
REQ-035 rst pulsed in the 2nd RUN cycle -> outputs zero at once, no done; the next start with mode 00, X=8'h3C -> Y=8'h3C.
REQ-036 Parameter sweep N=16 with K in {1, 4, 16}: random X and mode are checked against a reference model; latency equals N/K+1 in every case.
